// File: rtl/spi_master.sv
// SPI master: one transfer of up to 32 bits per start pulse, with programmable
// sclk half-period, byte count, CPOL and CPHA. Config and data are latched at start.
module spi_master (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] ctrl_reg,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic [31:0] status_reg,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        csn
);

    localparam logic [31:0] CFG_RESET = 32'h0000_020A;

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

    state_t      state;
    logic [31:0] cfg;
    logic [31:0] tx_sh;
    logic [31:0] rx_sh;
    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic        phase;
    logic        busy;
    logic        done;

    function automatic logic [7:0] eff_h(input logic [31:0] c);
        return (c[7:0] == 8'd0) ? 8'd1 : c[7:0];
    endfunction

    function automatic logic [5:0] eff_bits(input logic [31:0] c);
        if (c[15:8] == 8'd0 || c[15:8] > 8'd4)
            return 6'd32;
        return {c[10:8], 3'b000};
    endfunction

    logic [7:0]  h_last;
    logic [5:0]  bits_last;
    logic        cpol;
    logic        cpha;
    logic [31:0] start_aligned;

    assign h_last    = eff_h(cfg) - 8'd1;
    assign bits_last = eff_bits(cfg) - 6'd1;
    assign cpol      = cfg[16];
    assign cpha      = cfg[17];
    // Left-align the outgoing word so the first bit to send is always bit 31.
    assign start_aligned = din << (6'd32 - eff_bits(ctrl_reg));

    assign status_reg = {30'd0, done, busy};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cfg     <= CFG_RESET;
            tx_sh   <= '0;
            rx_sh   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            phase   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dout    <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            csn     <= 1'b1;
        end else begin
            // NOTE: all state here uses <= so every branch reads pre-edge values.
            case (state)
                IDLE: begin
                    sclk <= cpol;
                    mosi <= 1'b0;
                    csn  <= 1'b1;
                    if (start) begin
                        cfg     <= ctrl_reg;
                        tx_sh   <= ctrl_reg[17] ? start_aligned : (start_aligned << 1);
                        mosi    <= ctrl_reg[17] ? 1'b0 : start_aligned[31];
                        rx_sh   <= '0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        phase   <= 1'b0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        csn     <= 1'b0;
                        sclk    <= ctrl_reg[16];
                        state   <= LEAD;
                    end
                end

                LEAD: begin
                    if (div_cnt == h_last) begin
                        div_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                SHIFT: begin
                    if (div_cnt == h_last) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        phase   <= ~phase;
                        if (!phase) begin
                            if (cpha) begin
                                mosi  <= tx_sh[31];
                                tx_sh <= tx_sh << 1;
                            end else begin
                                rx_sh <= {rx_sh[30:0], miso};
                            end
                        end else begin
                            if (cpha) begin
                                rx_sh <= {rx_sh[30:0], miso};
                            end else if (bit_cnt != bits_last) begin
                                mosi  <= tx_sh[31];
                                tx_sh <= tx_sh << 1;
                            end
                            if (bit_cnt == bits_last)
                                state <= TRAIL;
                            else
                                bit_cnt <= bit_cnt + 6'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                TRAIL: begin
                    if (div_cnt == h_last) begin
                        div_cnt <= '0;
                        state   <= IDLE;
                        csn     <= 1'b1;
                        mosi    <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        dout    <= rx_sh;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback transfers in several modes, ignored
// restarts, mid-transfer reset and divisor/byte-count clamping.
module tb_spi_master;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] ctrl_reg;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] status_reg;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        csn;
    logic        miso_one;

    int tests_run;
    int tests_failed;
    int done_cnt;
    int mosi_viol;
    logic done_prev;

    spi_master dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ctrl_reg   (ctrl_reg),
        .din        (din),
        .dout       (dout),
        .status_reg (status_reg),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .csn        (csn)
    );

    assign miso = miso_one ? 1'b1 : mosi;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts done rising edges and any mosi activity while deselected.
    always @(posedge clk) begin
        #1;
        if (status_reg[1] && !done_prev) done_cnt <= done_cnt + 1;
        if (csn && mosi) mosi_viol <= mosi_viol + 1;
        done_prev <= status_reg[1];
    end

    task automatic run_xfer(input logic [31:0] ctrl, input logic [31:0] d, input int inject_at,
                            output int busy_n, output int csn_low_n, output int rises,
                            output int dones, output logic first_mosi, output logic first_sclk,
                            output logic [31:0] first_status);
        int   d0;
        logic prev_sclk;
        @(negedge clk);
        ctrl_reg = ctrl;
        din      = d;
        start    = 1'b1;
        d0       = done_cnt;
        @(negedge clk);
        start        = 1'b0;
        first_mosi   = mosi;
        first_sclk   = sclk;
        first_status = status_reg;
        prev_sclk    = sclk;
        busy_n       = 0;
        csn_low_n    = 0;
        rises        = 0;
        while (status_reg[0] && busy_n < 5000) begin
            busy_n++;
            if (!csn) csn_low_n++;
            if (sclk && !prev_sclk) rises++;
            prev_sclk = sclk;
            if (busy_n == inject_at) begin
                start    = 1'b1;
                din      = ~d;
                ctrl_reg = 32'h0003_0001;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        dones = done_cnt - d0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({csn, sclk, mosi} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_pins: got csn/sclk/mosi=%b expected 100", {csn, sclk, mosi});
        end
        tests_run++;
        if (dout !== 32'h0 || status_reg !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_regs: got dout=%h status=%h expected 0/0", dout, status_reg);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode0_basic;
        int busy_n, csn_low_n, rises, dones;
        logic fm, fs;
        logic [31:0] fst;
        miso_one = 1'b0;
        run_xfer(32'h0000_020A, 32'h0000_A55A, 0, busy_n, csn_low_n, rises, dones, fm, fs, fst);
        tests_run++;
        if (fst !== 32'h1) begin
            tests_failed++;
            $display("FAIL m0_start_status: got %h expected 00000001", fst);
        end
        tests_run++;
        if (fm !== 1'b1) begin
            tests_failed++;
            $display("FAIL m0_lead_mosi: got %b expected 1", fm);
        end
        tests_run++;
        if (rises !== 16) begin
            tests_failed++;
            $display("FAIL m0_rises: got %0d expected 16", rises);
        end
        tests_run++;
        if (csn_low_n !== 340 || busy_n !== 340) begin
            tests_failed++;
            $display("FAIL m0_duration: got csn_low=%0d busy=%0d expected 340", csn_low_n, busy_n);
        end
        tests_run++;
        if (dout !== 32'h0000_A55A || status_reg !== 32'h2) begin
            tests_failed++;
            $display("FAIL m0_result: got dout=%h status=%h expected 0000a55a/2", dout, status_reg);
        end
    endtask

    task automatic test_mode3_32bit;
        int busy_n, csn_low_n, rises, dones;
        logic fm, fs;
        logic [31:0] fst;
        miso_one = 1'b0;
        run_xfer(32'h0003_0001, 32'hDEAD_BEEF, 0, busy_n, csn_low_n, rises, dones, fm, fs, fst);
        tests_run++;
        if (fs !== 1'b1) begin
            tests_failed++;
            $display("FAIL m3_lead_sclk: got %b expected 1", fs);
        end
        tests_run++;
        if (rises !== 32 || busy_n !== 66) begin
            tests_failed++;
            $display("FAIL m3_timing: got rises=%0d busy=%0d expected 32/66", rises, busy_n);
        end
        tests_run++;
        if (dout !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL m3_dout: got %h expected deadbeef", dout);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (sclk !== 1'b1 || csn !== 1'b1) begin
            tests_failed++;
            $display("FAIL m3_idle: got sclk=%b csn=%b expected 1/1", sclk, csn);
        end
    endtask

    task automatic test_mode1_24bit;
        int busy_n, csn_low_n, rises, dones;
        logic fm, fs;
        logic [31:0] fst;
        miso_one = 1'b0;
        run_xfer(32'h0002_0302, 32'hFF12_3456, 0, busy_n, csn_low_n, rises, dones, fm, fs, fst);
        tests_run++;
        if (rises !== 24 || busy_n !== 100) begin
            tests_failed++;
            $display("FAIL m1_timing: got rises=%0d busy=%0d expected 24/100", rises, busy_n);
        end
        tests_run++;
        if (dout !== 32'h0012_3456) begin
            tests_failed++;
            $display("FAIL m1_dout: got %h expected 00123456", dout);
        end
    endtask

    task automatic test_ignored_start;
        int busy_n, csn_low_n, rises, dones;
        logic fm, fs;
        logic [31:0] fst;
        miso_one = 1'b0;
        run_xfer(32'h0000_020A, 32'h0000_1234, 5, busy_n, csn_low_n, rises, dones, fm, fs, fst);
        tests_run++;
        if (dout !== 32'h0000_1234) begin
            tests_failed++;
            $display("FAIL restart_dout: got %h expected 00001234", dout);
        end
        tests_run++;
        if (busy_n !== 340 || rises !== 16) begin
            tests_failed++;
            $display("FAIL restart_timing: got busy=%0d rises=%0d expected 340/16", busy_n, rises);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (done_cnt - (done_cnt - dones) !== 1 || status_reg !== 32'h2) begin
            tests_failed++;
            $display("FAIL restart_done: got dones=%0d status=%h expected 1/2", dones, status_reg);
        end
    endtask

    task automatic test_reset_mid;
        int   n, rises, d0, busy_n, csn_low_n, dones;
        logic prev_sclk, fm, fs;
        logic [31:0] fst;
        miso_one = 1'b0;
        @(negedge clk);
        ctrl_reg = 32'h0000_020A;
        din      = 32'h0000_A55A;
        start    = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        prev_sclk = sclk;
        n         = 0;
        rises     = 0;
        while (rises < 7 && n < 1000) begin
            @(negedge clk);
            n++;
            if (sclk && !prev_sclk) rises++;
            prev_sclk = sclk;
        end
        tests_run++;
        if (rises !== 7) begin
            tests_failed++;
            $display("FAIL rstmid_reach: got rises=%0d expected 7", rises);
        end
        d0 = done_cnt;
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (csn !== 1'b1 || status_reg !== 32'h0 || sclk !== 1'b0 || mosi !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_abort: got csn=%b status=%h sclk=%b mosi=%b expected 1/0/0/0",
                     csn, status_reg, sclk, mosi);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        tests_run++;
        if (dout !== 32'h0 || status_reg !== 32'h0 || done_cnt !== d0) begin
            tests_failed++;
            $display("FAIL rstmid_quiet: got dout=%h status=%h new_dones=%0d expected 0/0/0",
                     dout, status_reg, done_cnt - d0);
        end
        run_xfer(32'h0000_020A, 32'h0000_A55A, 0, busy_n, csn_low_n, rises, dones, fm, fs, fst);
        tests_run++;
        if (dout !== 32'h0000_A55A || busy_n !== 340 || dones !== 1) begin
            tests_failed++;
            $display("FAIL rstmid_next: got dout=%h busy=%0d dones=%0d expected 0000a55a/340/1",
                     dout, busy_n, dones);
        end
    endtask

    task automatic test_h_zero;
        int busy_n, csn_low_n, rises, dones;
        logic fm, fs;
        logic [31:0] fst;
        miso_one = 1'b1;
        run_xfer(32'h0000_0100, 32'h0000_0000, 0, busy_n, csn_low_n, rises, dones, fm, fs, fst);
        miso_one = 1'b0;
        tests_run++;
        if (dout !== 32'h0000_00FF) begin
            tests_failed++;
            $display("FAIL hzero_dout: got %h expected 000000ff", dout);
        end
        tests_run++;
        if (busy_n !== 18 || rises !== 8) begin
            tests_failed++;
            $display("FAIL hzero_timing: got busy=%0d rises=%0d expected 18/8", busy_n, rises);
        end
    endtask

    task automatic test_mosi_idle;
        repeat (2) @(negedge clk);
        tests_run++;
        if (mosi_viol !== 0) begin
            tests_failed++;
            $display("FAIL mosi_idle: got %0d cycles with mosi=1 and csn=1, expected 0", mosi_viol);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        done_cnt     = 0;
        mosi_viol    = 0;
        done_prev    = 1'b0;
        start        = 1'b0;
        ctrl_reg     = 32'h0;
        din          = 32'h0;
        miso_one     = 1'b0;
        test_reset();
        test_mode0_basic();
        test_mode3_32bit();
        test_mode1_24bit();
        test_ignored_start();
        test_reset_mid();
        test_h_zero();
        test_mosi_idle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 clk  input  1  System clock; all state updates on rising edge.
REQ-002 rst_n  input  1  Asynchronous, active-low reset; deassertion is synchronised to clk by the parent.
REQ-003 start  input  1  Transfer request pulse from the memory-mapped register block; sampled every clk.
REQ-004 ctrl_reg  input  32  Config: [7:0] half-period divisor H (sclk half-period in clk cycles); [15:8] byte count N; [16] CPOL; [17] CPHA; other bits ignored.
REQ-005 din  input  32  Transmit word; the low 8*N bits are sent MSB-first.
REQ-006 dout  output  32  Received word, right-justified, upper bits zero.
REQ-007 status_reg  output  32  [0] busy; [1] done; [31:2] zero.
REQ-008 sclk  output  1  SPI clock.
REQ-009 mosi  output  1  SPI data out.
REQ-010 miso  input  1  SPI data in; sampled directly, with no internal synchroniser.
REQ-011 csn  output  1  Active-low chip select.

Function
REQ-012 Idle outputs: csn=1, sclk=CPOL of the latched config, busy=0.
REQ-013 start=1 while idle latches ctrl_reg and din on that edge, clears done, and sets busy=1 and csn=0 on the next cycle.
REQ-014 start=1 while busy is ignored, with no effect on state, latched data or flags.
REQ-015 Effective H: 0 is treated as 1.
REQ-016 Effective N: 0 is treated as 4; values above 4 clamp to 4.
REQ-017 Effective bit count: B = 8*N.
REQ-018 The state machine is IDLE -> LEAD -> SHIFT -> TRAIL -> IDLE.
REQ-019 LEAD: csn=0, sclk held at CPOL, for H cycles.
REQ-020 LEAD: for CPHA=0, mosi presents bit B-1 throughout LEAD.
REQ-021 SHIFT: sclk toggles every H cycles; exactly 2*B toggles occur, giving B leading edges and B trailing edges.
REQ-022 CPHA=0: miso is sampled on each leading edge; mosi advances to the next bit on each trailing edge except the last.
REQ-023 CPHA=1: mosi advances on each leading edge, starting with bit B-1; miso is sampled on each trailing edge.
REQ-024 Received bits shift in LSB-first into the receive shift register, so the first bit received ends at dout bit B-1.
REQ-025 TRAIL: sclk=CPOL and csn=0, for H cycles.
REQ-026 On TRAIL exit (same edge): csn=1, busy=0, done=1, and dout is loaded with the receive shift register.
REQ-027 dout holds its value until the next completed transfer.
REQ-028 Total busy duration: exactly (2 + 2*B)*H cycles.
REQ-029 done stays sticky until the next accepted start.
REQ-030 mosi=0 whenever csn=1.
REQ-031 Divisor counter width is 8 bits; no overflow is possible for H up to 255.
REQ-032 A bit counter of 6 bits suffices for B up to 32.
REQ-033 A ctrl_reg or din change during busy does not affect the transfer in progress.

Reset
REQ-034 rst_n=0 forces immediately, without waiting for clk: state=IDLE, csn=1, sclk=0, mosi=0, dout=0, status_reg=0.
REQ-035 Internal latched config resets to 0x0000020A.
REQ-036 Reset asserted mid-transfer aborts the transfer.
REQ-037 After a mid-transfer reset, no done and no dout update occur; the next start after rst_n=1 begins a fresh transfer.

Verification
REQ-038 ctrl_reg=0x0000020A, din=0x0000A55A, miso looped to mosi, one start pulse -> 16 sclk rising edges, csn low for 340 cycles, then dout=0x0000A55A, status_reg=0x2.
REQ-039 ctrl_reg=0x00030001 (mode 3, H=1, N=0 -> 32 bits), din=0xDEADBEEF, loopback -> sclk idles high, 32 rising edges, dout=0xDEADBEEF, busy for 66 cycles.
REQ-040 Second start 5 cycles into a transfer, with different din -> ignored; dout reflects the first din only; exactly one done.
REQ-041 rst_n pulsed low at bit 7 of a 16-bit transfer -> csn=1 and status_reg=0 within the same cycle; dout stays 0; a following start completes normally.
REQ-042 miso tied 1, N=1, H=0 -> H treated as 1; dout=0x000000FF; busy for 18 cycles.
